// File: rtl/data_mem_controller.sv
`timescale 1ns/1ps
// Data-memory controller: arbitrates per-lane LSU read/write requests onto NUM_CHANNELS
// external memory channels. Define MEM_CTRL_RR_ARB_EN for round-robin lane selection.
module data_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int WRITE_EN      = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int LANE_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELAY_READ,
    RELAY_WRITE
  } ch_state_t;

  typedef logic [LANE_W-1:0] lane_t;

  ch_state_t state_q [NUM_CHANNELS];
  ch_state_t state_d [NUM_CHANNELS];
  lane_t     owner_q [NUM_CHANNELS];
  lane_t     owner_d [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0] claimed_q, claimed_d;
  logic [NUM_CONSUMERS-1:0] write_pending;
  logic [NUM_CONSUMERS-1:0] pending;

  logic [NUM_CHANNELS-1:0]                 rd_valid_d, wr_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  rd_addr_d, wr_addr_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  wr_data_d;
  logic [NUM_CONSUMERS-1:0]                rd_ready_d, wr_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_d;

  int search_base;

`ifdef MEM_CTRL_RR_ARB_EN
  lane_t rr_ptr_q, rr_ptr_d;
  assign search_base = int'(rr_ptr_q);
`else
  assign search_base = 0;
`endif

  // A read-only memory never presents write work to the arbiter.
  if (WRITE_EN != 0) begin : g_write
    assign write_pending = consumer_write_valid;
  end else begin : g_no_write
    assign write_pending = '0;
  end

  assign pending = consumer_read_valid | write_pending;

  always_comb begin
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    lane_t                    sel;
    int                       idx;

    // NOTE: every signal written here gets a hold default first, so no path can infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    claimed_d  = claimed_q;
    rd_valid_d = mem_read_valid;
    rd_addr_d  = mem_read_address;
    wr_valid_d = mem_write_valid;
    wr_addr_d  = mem_write_address;
    wr_data_d  = mem_write_data;
    rd_ready_d = consumer_read_ready;
    rd_data_d  = consumer_read_data;
    wr_ready_d = consumer_write_ready;
`ifdef MEM_CTRL_RR_ARB_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    // Grants made this cycle are visible to higher channels; releases only count next cycle.
    taken = claimed_q;
    found = 1'b0;
    sel   = '0;
    idx   = 0;

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (state_q[c])
        IDLE: begin
          found = 1'b0;
          sel   = '0;
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            idx = search_base + k;
            if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
            if (!found && pending[idx] && !taken[idx]) begin
              found = 1'b1;
              sel   = lane_t'(idx);
            end
          end
          if (found) begin
            taken[sel]     = 1'b1;
            claimed_d[sel] = 1'b1;
            owner_d[c]     = sel;
            if (consumer_read_valid[sel]) begin
              state_d[c]    = READ_WAIT;
              rd_valid_d[c] = 1'b1;
              rd_addr_d[c]  = consumer_read_address[sel];
            end else begin
              state_d[c]    = WRITE_WAIT;
              wr_valid_d[c] = 1'b1;
              wr_addr_d[c]  = consumer_write_address[sel];
              wr_data_d[c]  = consumer_write_data[sel];
            end
`ifdef MEM_CTRL_RR_ARB_EN
            // Channels run in index order, so the final write holds the last granted lane.
            rr_ptr_d = (int'(sel) == NUM_CONSUMERS - 1) ? '0 : lane_t'(sel + 1'b1);
`endif
          end
        end

        READ_WAIT: begin
          if (mem_read_ready[c]) begin
            rd_valid_d[c]             = 1'b0;
            rd_data_d[owner_q[c]]     = mem_read_data[c];
            rd_ready_d[owner_q[c]]    = 1'b1;
            state_d[c]                = RELAY_READ;
          end
        end

        WRITE_WAIT: begin
          if (mem_write_ready[c]) begin
            wr_valid_d[c]             = 1'b0;
            wr_ready_d[owner_q[c]]    = 1'b1;
            state_d[c]                = RELAY_WRITE;
          end
        end

        RELAY_READ: begin
          if (!consumer_read_valid[owner_q[c]]) begin
            rd_ready_d[owner_q[c]] = 1'b0;
            claimed_d[owner_q[c]]  = 1'b0;
            state_d[c]             = IDLE;
          end
        end

        RELAY_WRITE: begin
          if (!consumer_write_valid[owner_q[c]]) begin
            wr_ready_d[owner_q[c]] = 1'b0;
            claimed_d[owner_q[c]]  = 1'b0;
            state_d[c]             = IDLE;
          end
        end

        default: state_d[c] = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the per-channel and per-lane arrays are all reset: outputs must read 0 and in-flight work is dropped.
      state_q              <= '{default: IDLE};
      owner_q              <= '{default: '0};
      claimed_q            <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
`ifdef MEM_CTRL_RR_ARB_EN
      rr_ptr_q             <= '0;
`endif
    end else begin
      state_q              <= state_d;
      owner_q              <= owner_d;
      claimed_q            <= claimed_d;
      mem_read_valid       <= rd_valid_d;
      mem_read_address     <= rd_addr_d;
      mem_write_valid      <= wr_valid_d;
      mem_write_address    <= wr_addr_d;
      mem_write_data       <= wr_data_d;
      consumer_read_ready  <= rd_ready_d;
      consumer_read_data   <= rd_data_d;
      consumer_write_ready <= wr_ready_d;
`ifdef MEM_CTRL_RR_ARB_EN
      rr_ptr_q             <= rr_ptr_d;
`endif
    end
  end

endmodule
